decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The module SHALL have parameter RV32E, default 0, meaning 1 restricts register indices to x0..x15.
REQ-002 The module SHALL have parameter EN_M, default 1, meaning 1 decodes M-extension (MUL/DIV) as legal.
REQ-003 The module SHALL have parameter EN_ZICSR, default 1, meaning 1 decodes CSR instructions as legal.
REQ-004 The module SHALL have parameter CNT_W, default 16, meaning width of the illegal-instruction counter.
REQ-005 The module SHALL have one clock and an asynchronous active-low reset: clk_i in 1, rising-edge clock; rst_ni in 1, async active-low reset.
REQ-006 The module SHALL have these input-side ports:
- flush_i in 1: discard the held and incoming beat.
- in_valid_i in 1: instruction beat valid.
- in_ready_o out 1: stage can accept.
- instr_i in 32: instruction word.
- pc_i in 32: instruction address.
REQ-007 The module SHALL have these output-side ports:
- out_valid_o out 1: decoded beat valid.
- out_ready_i in 1: downstream accepts.
- pc_o out 32: registered pc.
- rd_sel_o, rs1_sel_o, rs2_sel_o out 5 each: register indices.
- imm_o out 32: sign-extended immediate.
REQ-008 The module SHALL have these decoded-control and status outputs:
- op_class_o out 4: operation class.
- func_o out 4: {instr[30], func3}.
- rf_we_o out 1: register write enable.
- illegal_o out 1: illegal instruction.
- illegal_cnt_o out CNT_W: saturating illegal count.

Function
REQ-009 in_ready_o SHALL equal (!out_valid_o || out_ready_i), combinationally.
REQ-010 A beat SHALL be accepted when in_valid_i && in_ready_o && !flush_i, and all decoded outputs SHALL be registered with exactly 1 cycle latency.
REQ-011 While out_valid_o=1 and out_ready_i=0, every output SHALL hold stable.
REQ-012 When a beat is consumed (out_valid_o && out_ready_i) and no new beat is accepted, out_valid_o SHALL go to 0 the next cycle.
REQ-013 flush_i=1 SHALL clear out_valid_o the next cycle and drop any same-cycle input beat; flush_i has priority over all other events.
REQ-014 op_class_o SHALL be encoded as: 0 illegal, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OP-IMM, 9 OP, 10 MULDIV, 11 CSR, 12 FENCE, 13 ECALL/EBREAK.
REQ-015 imm_o SHALL follow the standard RV32 I/S/B/U/J formats per class, and SHALL be 0 for OP, MULDIV, FENCE, SYSTEM and illegal beats.
REQ-016 rf_we_o SHALL be 1 for classes 1,2,3,4,6,8,9,10,11 when rd≠0, and 0 otherwise.
REQ-017 illegal_o SHALL be 1 when any of the following holds:
- instr[1:0]≠2'b11, or an unlisted opcode;
- JALR func3≠0;
- branch func3 of 010 or 011;
- load func3 of 011 or ≥110, or store func3 ≥011;
- bad func7 on shifts or OP;
- MULDIV with EN_M=0, or CSR with EN_ZICSR=0;
- RV32E=1 and any used register index ≥16.
REQ-018 An illegal beat SHALL force op_class_o=0, rf_we_o=0 and imm_o=0, and SHALL still pass through the handshake.
REQ-019 illegal_cnt_o SHALL increment by 1 on each accepted illegal beat and saturate at all-ones without wrap.

Reset
REQ-020 While rst_ni=0, out_valid_o, illegal_cnt_o and all registered outputs SHALL be 0 asynchronously.
REQ-021 Reset asserted mid-transfer SHALL discard the held beat; the first beat after deassertion SHALL be accepted normally.

Verification
REQ-022 Bench SHALL cover: ADDI x1,x0,5 (0x00500093), out_ready_i=1 -> next cycle out_valid_o=1, op_class_o=8, rd_sel_o=1, imm_o=5, rf_we_o=1.
REQ-023 Bench SHALL cover: held beat with out_ready_i=0 for 3 cycles -> in_ready_o=0 and outputs unchanged; on release the next beat follows with no bubble.
REQ-024 Bench SHALL cover: EN_M=0, instr 0x022080B3 -> illegal_o=1, op_class_o=0, rf_we_o=0, illegal_cnt_o 0->1.
REQ-025 Bench SHALL cover: RV32E=1, instr 0x00000833 (add x16) -> illegal_o=1.
REQ-026 Bench SHALL cover: flush_i pulsed with a beat held and in_valid_i=1 -> out_valid_o=0 next cycle and illegal_cnt_o unchanged.
REQ-027 Bench SHALL cover: CNT_W=4 with 17 illegal beats -> illegal_cnt_o=4'hF.

Source files
------------

// File: rtl/decode_pipe.sv
// Single-stage RV32 instruction decoder behind a valid/ready register slice,
// with a saturating count of accepted illegal instructions.
module decode_pipe #(
  parameter int RV32E    = 0,
  parameter int EN_M     = 1,
  parameter int EN_ZICSR = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      pc_o,
  output logic [4:0]       rd_sel_o,
  output logic [4:0]       rs1_sel_o,
  output logic [4:0]       rs2_sel_o,
  output logic [31:0]      imm_o,
  output logic [3:0]       op_class_o,
  output logic [3:0]       func_o,
  output logic             rf_we_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [3:0] CLS_ILLEGAL = 4'd0,  CLS_LUI   = 4'd1,  CLS_AUIPC  = 4'd2;
  localparam logic [3:0] CLS_JAL     = 4'd3,  CLS_JALR  = 4'd4,  CLS_BRANCH = 4'd5;
  localparam logic [3:0] CLS_LOAD    = 4'd6,  CLS_STORE = 4'd7,  CLS_OPIMM  = 4'd8;
  localparam logic [3:0] CLS_OP      = 4'd9,  CLS_MULDIV = 4'd10, CLS_CSR   = 4'd11;
  localparam logic [3:0] CLS_FENCE   = 4'd12, CLS_SYS   = 4'd13;

  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic [4:0]       rdIdx, rs1Idx, rs2Idx;
  logic [31:0]      immI, immS, immB, immU, immJ;
  logic             useRd, useRs1, useRs2, legal, decWe;
  logic [3:0]       decClass;
  logic [31:0]      decImm;
  logic             accept, valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, imm_q;
  logic [4:0]       rd_q, rs1_q, rs2_q;
  logic [3:0]       class_q, func_q;
  logic             we_q, illegal_q;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rdIdx  = instr_i[11:7];
  assign rs1Idx = instr_i[19:15];
  assign rs2Idx = instr_i[24:20];

  assign immI = {{20{instr_i[31]}}, instr_i[31:20]};
  assign immS = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign immB = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign immU = {instr_i[31:12], 12'h000};
  assign immJ = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    decClass = CLS_ILLEGAL;
    decImm   = '0;
    useRd    = 1'b0;
    useRs1   = 1'b0;
    useRs2   = 1'b0;
    legal    = 1'b1;
    decWe    = 1'b0;
    case (opcode)
      7'b0110111: begin decClass = CLS_LUI;   decImm = immU; useRd = 1'b1; end
      7'b0010111: begin decClass = CLS_AUIPC; decImm = immU; useRd = 1'b1; end
      7'b1101111: begin decClass = CLS_JAL;   decImm = immJ; useRd = 1'b1; end
      7'b1100111: begin
        decClass = CLS_JALR; decImm = immI; useRd = 1'b1; useRs1 = 1'b1;
        legal = (funct3 == 3'b000);
      end
      7'b1100011: begin
        decClass = CLS_BRANCH; decImm = immB; useRs1 = 1'b1; useRs2 = 1'b1;
        legal = (funct3[2:1] != 2'b01);
      end
      7'b0000011: begin
        decClass = CLS_LOAD; decImm = immI; useRd = 1'b1; useRs1 = 1'b1;
        legal = (funct3 != 3'b011) && (funct3 < 3'b110);
      end
      7'b0100011: begin
        decClass = CLS_STORE; decImm = immS; useRs1 = 1'b1; useRs2 = 1'b1;
        legal = (funct3 < 3'b011);
      end
      7'b0010011: begin
        decClass = CLS_OPIMM; decImm = immI; useRd = 1'b1; useRs1 = 1'b1;
        if (funct3 == 3'b001)
          legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      end
      7'b0110011: begin
        useRd = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1;
        if (funct7 == 7'b0000001) begin
          decClass = CLS_MULDIV;
          legal    = (EN_M != 0);
        end else begin
          decClass = CLS_OP;
          legal    = (funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end
      end
      7'b0001111: decClass = CLS_FENCE;
      7'b1110011: begin
        // Immediate CSR forms reuse the rs1 field as a 5-bit constant
        if (funct3 == 3'b000) begin
          decClass = CLS_SYS;
        end else begin
          decClass = CLS_CSR;
          useRd    = 1'b1;
          useRs1   = !funct3[2];
          legal    = (EN_ZICSR != 0);
        end
      end
      default: legal = 1'b0;
    endcase
    if ((RV32E != 0) && ((useRd && rdIdx[4]) || (useRs1 && rs1Idx[4]) || (useRs2 && rs2Idx[4])))
      legal = 1'b0;
    if (!legal) begin
      decClass = CLS_ILLEGAL;
      decImm   = '0;
    end
    case (decClass)
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD,
      CLS_OPIMM, CLS_OP, CLS_MULDIV, CLS_CSR: decWe = (rdIdx != 5'd0);
      default: decWe = 1'b0;
    endcase
  end

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush_i)
      valid_d = 1'b0;
    else if (accept)
      valid_d = 1'b1;
    else if (out_ready_i)
      valid_d = 1'b0;
    if (accept && !legal && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      class_q   <= '0;
      func_q    <= '0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pc_q      <= pc_i;
        imm_q     <= decImm;
        rd_q      <= rdIdx;
        rs1_q     <= rs1Idx;
        rs2_q     <= rs2Idx;
        class_q   <= decClass;
        func_q    <= {instr_i[30], funct3};
        we_q      <= decWe;
        illegal_q <= !legal;
      end
    end
  end

  assign out_valid_o   = valid_q;
  assign illegal_cnt_o = cnt_q;
  assign pc_o          = pc_q;
  assign imm_o         = imm_q;
  assign rd_sel_o      = rd_q;
  assign rs1_sel_o     = rs1_q;
  assign rs2_sel_o     = rs2_q;
  assign op_class_o    = class_q;
  assign func_o        = func_q;
  assign rf_we_o       = we_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Drives a default decode_pipe and a restricted one (RV32E, no M, no Zicsr, 4-bit
// counter) with shared directed and random beats, checked against a reference model.
module tb_decode_pipe;

  typedef struct packed {
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        we;
    logic        ill;
  } decRef_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, flush, inValid, outReady;
  logic [31:0] instr, pc;

  logic        inReady0, outValid0, rfWe0, illegal0;
  logic [31:0] pcO0, imm0;
  logic [4:0]  rd0, rs10, rs20;
  logic [3:0]  cls0, func0;
  logic [15:0] cnt0;

  logic        inReady1, outValid1, rfWe1, illegal1;
  logic [31:0] pcO1, imm1;
  logic [4:0]  rd1, rs11, rs21;
  logic [3:0]  cls1, func1;
  logic [3:0]  cnt1;

  int nCmp = 0;
  int nFail = 0;

  logic        expValid;
  logic [31:0] expInstr, expPc;
  int          expCnt0, expCnt1;

  decode_pipe dut0 (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady0),
    .instr_i(instr), .pc_i(pc), .out_valid_o(outValid0), .out_ready_i(outReady), .pc_o(pcO0),
    .rd_sel_o(rd0), .rs1_sel_o(rs10), .rs2_sel_o(rs20), .imm_o(imm0), .op_class_o(cls0),
    .func_o(func0), .rf_we_o(rfWe0), .illegal_o(illegal0), .illegal_cnt_o(cnt0)
  );

  decode_pipe #(.RV32E(1), .EN_M(0), .EN_ZICSR(0), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady1),
    .instr_i(instr), .pc_i(pc), .out_valid_o(outValid1), .out_ready_i(outReady), .pc_o(pcO1),
    .rd_sel_o(rd1), .rs1_sel_o(rs11), .rs2_sel_o(rs21), .imm_o(imm1), .op_class_o(cls1),
    .func_o(func1), .rf_we_o(rfWe1), .illegal_o(illegal1), .illegal_cnt_o(cnt1)
  );

  // Reference decode: class from opcode, legality from the listed field rules, immediates by arithmetic
  function automatic decRef_t refDecode(logic [31:0] w, bit rv32e, bit enM, bit enCsr);
    decRef_t r;
    int op, f3, f7;
    bit ok, uRd, uRs1, uRs2;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    r = '0; ok = 1; uRd = 0; uRs1 = 0; uRs2 = 0;
    case (op)
      'h37: begin r.cls = 1; uRd = 1; r.imm = int'(w[31:12]) * 4096; end
      'h17: begin r.cls = 2; uRd = 1; r.imm = int'(w[31:12]) * 4096; end
      'h6F: begin r.cls = 3; uRd = 1; r.imm = int'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2; end
      'h67: begin r.cls = 4; uRd = 1; uRs1 = 1; ok = (f3 == 0); r.imm = int'($signed(w[31:20])); end
      'h63: begin r.cls = 5; uRs1 = 1; uRs2 = 1; ok = !(f3 inside {2, 3});
                  r.imm = int'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2; end
      'h03: begin r.cls = 6; uRd = 1; uRs1 = 1; ok = (f3 inside {0, 1, 2, 4, 5}); r.imm = int'($signed(w[31:20])); end
      'h23: begin r.cls = 7; uRs1 = 1; uRs2 = 1; ok = (f3 <= 2); r.imm = int'($signed({w[31:25], w[11:7]})); end
      'h13: begin r.cls = 8; uRd = 1; uRs1 = 1; r.imm = int'($signed(w[31:20]));
                  if (f3 == 1) ok = (f7 == 0);
                  if (f3 == 5) ok = (f7 == 0) || (f7 == 32); end
      'h33: begin uRd = 1; uRs1 = 1; uRs2 = 1;
                  if (f7 == 1) begin r.cls = 10; ok = enM; end
                  else begin r.cls = 9; ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end end
      'h0F: r.cls = 12;
      'h73: if (f3 == 0) r.cls = 13;
            else begin r.cls = 11; ok = enCsr; uRd = 1; uRs1 = (f3 < 4); end
      default: ok = 0;
    endcase
    if (rv32e && ((uRd && w[11:7] >= 16) || (uRs1 && w[19:15] >= 16) || (uRs2 && w[24:20] >= 16)))
      ok = 0;
    if (!ok) begin
      r.cls = 0;
      r.imm = 0;
    end
    if (r.cls inside {9, 10, 11, 12, 13}) r.imm = 0;
    r.we  = (r.cls inside {1, 2, 3, 4, 6, 8, 9, 10, 11}) && (w[11:7] != 0);
    r.ill = !ok;
    return r;
  endfunction

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkDec(string who, decRef_t d, logic [31:0] pcO, logic [4:0] rd, logic [4:0] rs1,
                          logic [4:0] rs2, logic [3:0] fn, logic [3:0] cls, logic [31:0] imm,
                          logic we, logic ill);
    checkVal({who, "_pc"}, pcO, expPc);
    checkVal({who, "_rd"}, rd, expInstr[11:7]);
    checkVal({who, "_rs1"}, rs1, expInstr[19:15]);
    checkVal({who, "_rs2"}, rs2, expInstr[24:20]);
    checkVal({who, "_func"}, fn, {expInstr[30], expInstr[14:12]});
    checkVal({who, "_class"}, cls, d.cls);
    checkVal({who, "_imm"}, imm, d.imm);
    checkVal({who, "_we"}, we, d.we);
    checkVal({who, "_illegal"}, ill, d.ill);
  endtask

  task automatic checkOutput();
    checkVal("valid0", outValid0, expValid);
    checkVal("valid1", outValid1, expValid);
    checkVal("cnt0", cnt0, expCnt0);
    checkVal("cnt1", cnt1, expCnt1);
    if (expValid) begin
      checkDec("d0", refDecode(expInstr, 0, 1, 1), pcO0, rd0, rs10, rs20, func0, cls0, imm0, rfWe0, illegal0);
      checkDec("d1", refDecode(expInstr, 1, 0, 0), pcO1, rd1, rs11, rs21, func1, cls1, imm1, rfWe1, illegal1);
    end
  endtask

  task automatic applyStimulus(logic v, logic [31:0] ins, logic [31:0] p, logic rdy, logic fl);
    inValid  = v;
    instr    = ins;
    pc       = p;
    outReady = rdy;
    flush    = fl;
  endtask

  // One clock: check ready, advance the model at the edge, check outputs just after
  task automatic stepCycle();
    logic expReady, acc;
    #1;
    expReady = !expValid || outReady;
    checkVal("in_ready0", inReady0, expReady);
    checkVal("in_ready1", inReady1, expReady);
    acc = inValid && expReady && !flush;
    @(posedge clk);
    if (flush) begin
      expValid = 0;
    end else if (acc) begin
      expValid = 1;
      expInstr = instr;
      expPc    = pc;
      if (refDecode(instr, 0, 1, 1).ill && expCnt0 < 65535) expCnt0++;
      if (refDecode(instr, 1, 0, 0).ill && expCnt1 < 15) expCnt1++;
    end else if (outReady) begin
      expValid = 0;
    end
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rstN = 1'b0;
    #2;
    checkVal("rst_valid0", outValid0, 0);
    checkVal("rst_valid1", outValid1, 0);
    checkVal("rst_cnt0", cnt0, 0);
    checkVal("rst_cnt1", cnt1, 0);
    checkVal("rst_pc0", pcO0, 0);
    checkVal("rst_imm0", imm0, 0);
    checkVal("rst_class0", cls0, 0);
    checkVal("rst_rd0", rd0, 0);
    checkVal("rst_we0", rfWe0, 0);
    checkVal("rst_illegal0", illegal0, 0);
    expValid = 0;
    expCnt0  = 0;
    expCnt1  = 0;
    @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  initial begin
    logic [6:0]  opList [11];
    logic [6:0]  f7List [3];
    logic [31:0] r;
    opList = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    f7List = '{7'h00, 7'h20, 7'h01};
    expInstr = '0;
    expPc    = '0;
    applyStimulus(0, 0, 0, 1, 0);
    doReset();

    applyStimulus(1, 32'h00500093, 32'h100, 1, 0);
    stepCycle();
    checkVal("addi_valid", outValid0, 1);
    checkVal("addi_class", cls0, 8);
    checkVal("addi_rd", rd0, 1);
    checkVal("addi_imm", imm0, 5);
    checkVal("addi_we", rfWe0, 1);

    applyStimulus(1, 32'h00A00113, 32'h104, 1, 0);
    stepCycle();
    applyStimulus(1, 32'h002081B3, 32'h108, 0, 0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkVal("hold_in_ready", inReady0, 0);
      checkVal("hold_rd", rd0, 2);
      checkVal("hold_imm", imm0, 10);
    end
    applyStimulus(1, 32'h002081B3, 32'h108, 1, 0);
    stepCycle();
    checkVal("nobubble_valid", outValid0, 1);
    checkVal("nobubble_rd", rd0, 3);
    applyStimulus(0, 0, 0, 1, 0);
    stepCycle();
    checkVal("drain_valid", outValid0, 0);

    checkVal("mul_cnt_before", cnt1, 0);
    applyStimulus(1, 32'h022080B3, 32'h10C, 1, 0);
    stepCycle();
    checkVal("mul_illegal1", illegal1, 1);
    checkVal("mul_class1", cls1, 0);
    checkVal("mul_we1", rfWe1, 0);
    checkVal("mul_cnt1", cnt1, 1);
    checkVal("mul_class0", cls0, 10);

    applyStimulus(1, 32'h00000833, 32'h110, 1, 0);
    stepCycle();
    checkVal("x16_illegal1", illegal1, 1);
    checkVal("x16_illegal0", illegal0, 0);

    applyStimulus(1, 32'hFFFFFFFF, 32'h114, 0, 0);
    stepCycle();
    applyStimulus(1, 32'h00000000, 32'h118, 0, 1);
    stepCycle();
    checkVal("flush_valid0", outValid0, 0);
    checkVal("flush_valid1", outValid1, 0);
    checkVal("flush_cnt1", cnt1, 2);
    checkVal("flush_cnt0", cnt0, 0);

    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 32'h00000000, 32'h200 + 4 * i, 1, 0);
      stepCycle();
    end
    checkVal("sat_cnt1", cnt1, 4'hF);
    checkVal("sat_cnt0", cnt0, 17);

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        r[6:0] = opList[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) r[31:25] = f7List[$urandom_range(0, 2)];
      end
      applyStimulus($urandom_range(0, 3) != 0, r, $urandom, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0);
      stepCycle();
    end

    applyStimulus(1, 32'h00A00113, 32'h300, 1, 0);
    stepCycle();
    applyStimulus(1, 32'h002081B3, 32'h304, 0, 0);
    stepCycle();
    doReset();
    applyStimulus(1, 32'h00500093, 32'h308, 1, 0);
    stepCycle();
    checkVal("post_rst_valid", outValid0, 1);
    checkVal("post_rst_rd", rd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
